// File: rtl/io_display_ctrl_if.sv
// ----------------------------------------------------------------------------
// io_display_ctrl_if
//   Processor IO port bundle between the MIPS core and io_display_ctrl.
//
//   Signals:
//     IOAddr       4-bit IO register address
//     IOWriteData  32-bit write data
//     IOWriteEn    write strobe, one CLK per write
//     IOReadData   32-bit read data, combinational from IOAddr
//
//   Modports:
//     master  processor side (drives address/write, receives read data)
//     slave   peripheral side (io_display_ctrl)
// ----------------------------------------------------------------------------
interface io_display_ctrl_if;
  logic [3:0]  IOAddr;
  logic [31:0] IOWriteData;
  logic        IOWriteEn;
  logic [31:0] IOReadData;

  modport master (
    output IOAddr,
    output IOWriteData,
    output IOWriteEn,
    input  IOReadData
  );

  modport slave (
    input  IOAddr,
    input  IOWriteData,
    input  IOWriteEn,
    output IOReadData
  );
endinterface

// File: rtl/io_display_ctrl.sv
// ----------------------------------------------------------------------------
// io_display_ctrl
//   Memory-mapped IO controller for a 4-digit multiplexed 7-segment display
//   and 8 slide switches.
//
//   Register map (IOAddr):
//     0x0 DATA   R/W  16-bit value shown as four hex digits
//     0x1 CTRL   R/W  4-bit digit enable mask (bit i enables digit i)
//     0x2 SW     RO   synchronized switches
//     0x3 FRAME  RO   8-bit scan frame counter
//     0x4-0xF         read as 0, writes ignored
//
//   Ports:
//     CLK      in   system clock
//     RESET    in   synchronous active-high reset
//     bus      slave modport of io_display_ctrl_if (IOAddr/IOWriteData/
//              IOWriteEn/IOReadData)
//     Sw       in   8 raw slide switches (asynchronous)
//     LED      out  7 segment cathodes, active-low, registered
//     AN       out  4 digit anodes, active-low one-hot, registered
//
//   Parameters:
//     SCAN_DIV      CLK cycles per digit slot (>= 2)
//     BLANK_CYCLES  dead-time cycles at the start of each slot (< SCAN_DIV),
//                   only used when IO_DISP_BLANK_EN is defined
//
//   Build option:
//     IO_DISP_BLANK_EN  when defined, blanks the display for the first
//                       BLANK_CYCLES cycles of every slot (anti-ghosting).
// ----------------------------------------------------------------------------
module io_display_ctrl #(
  parameter int SCAN_DIV     = 16384,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 RESET,
  io_display_ctrl_if.slave     bus,
  input  logic [7:0]           Sw,
  output logic [6:0]           LED,
  output logic [3:0]           AN
);

  localparam int                SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  // Elaboration-time configuration checks.
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("io_display_ctrl: SCAN_DIV must be >= 2");
  end
  if (BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
    $error("io_display_ctrl: BLANK_CYCLES must be < SCAN_DIV");
  end

  // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [15:0]       r_data;
  logic [3:0]        r_ctrl;
  logic [7:0]        r_sw_meta;
  logic [7:0]        r_sw_sync;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [1:0]        r_digit;
  logic [7:0]        r_frame_cnt;
  logic [6:0]        r_led;
  logic [3:0]        r_an;

  logic              w_blank;
  logic              w_digit_on;
  logic [3:0]        w_nibble;
  logic [31:0]       w_rdata;

  // Register writes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_data <= 16'h0000;
      r_ctrl <= 4'hF;
    end else if (bus.IOWriteEn) begin
      case (bus.IOAddr)
        4'h0:    r_data <= bus.IOWriteData[15:0];
        4'h1:    r_ctrl <= bus.IOWriteData[3:0];
        default: ;
      endcase
    end
  end

  // Two-flop switch synchronizer
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sw_meta <= 8'h00;
      r_sw_sync <= 8'h00;
    end else begin
      r_sw_meta <= Sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Scan sequencer: slot counter -> digit -> frame counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_slot_cnt  <= '0;
      r_digit     <= 2'd0;
      r_frame_cnt <= 8'd0;
    end else if (r_slot_cnt == SLOT_LAST) begin
      r_slot_cnt <= '0;
      r_digit    <= r_digit + 2'd1;
      if (r_digit == 2'd3) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

`ifdef IO_DISP_BLANK_EN
  assign w_blank = (r_slot_cnt < SLOT_W'(BLANK_CYCLES));
`else
  assign w_blank = 1'b0;
`endif

  // Output stage sees the live DATA/CTRL, so a write shows up one edge later
  // without waiting for a slot boundary.
  assign w_digit_on = r_ctrl[r_digit] & ~w_blank;
  assign w_nibble   = r_data[{r_digit, 2'b00} +: 4];

  // Output register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_an  <= 4'hF;
      r_led <= 7'h7F;
    end else if (w_digit_on) begin
      r_an  <= ~(4'b0001 << r_digit);
      r_led <= hex7(w_nibble);
    end else begin
      r_an  <= 4'hF;
      r_led <= 7'h7F;
    end
  end

  assign AN  = r_an;
  assign LED = r_led;

  // Read mux
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (bus.IOAddr)
      4'h0:    w_rdata = {16'h0000, r_data};
      4'h1:    w_rdata = {28'h0000000, r_ctrl};
      4'h2:    w_rdata = {24'h000000, r_sw_sync};
      4'h3:    w_rdata = {24'h000000, r_frame_cnt};
      default: w_rdata = 32'h0000_0000;
    endcase
  end

  assign bus.IOReadData = w_rdata;

endmodule

// File: tb/tb_io_display_ctrl.sv
// ----------------------------------------------------------------------------
// tb_io_display_ctrl
//   Self-checking bench for io_display_ctrl with SCAN_DIV=4, BLANK_CYCLES=1.
//   The reference model tracks the number of edges since reset release and
//   derives digit, slot and frame from it arithmetically.
// ----------------------------------------------------------------------------
module tb_io_display_ctrl;
  localparam int SD = 4;
  localparam int BC = 1;

  logic       CLK;
  logic       RESET;
  logic [7:0] Sw;
  logic [6:0] LED;
  logic [3:0] AN;

  io_display_ctrl_if bus();

  io_display_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .Sw    (Sw),
    .LED   (LED),
    .AN    (AN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model state
  int          m_t;       // edges since reset release
  logic [15:0] m_data;
  logic [3:0]  m_ctrl;
  logic [7:0]  m_sw_prev; // Sw captured at the previous edge
  logic [7:0]  m_sw_sync;
  logic [3:0]  exp_an;
  logic [6:0]  exp_led;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'h0:    m_read = {16'h0, m_data};
      4'h1:    m_read = {28'h0, m_ctrl};
      4'h2:    m_read = {24'h0, m_sw_sync};
      4'h3:    m_read = 32'((m_t / (4 * SD)) % 256);
      default: m_read = 32'h0;
    endcase
  endfunction

  // Advance one edge with the inputs currently driven, updating the model.
  task automatic tick();
    logic        rst;
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic [1:0]  d;
    bit          on;
    rst = RESET; wen = bus.IOWriteEn; addr = bus.IOAddr;
    wdata = bus.IOWriteData; sw = Sw;
    if (rst) begin
      exp_an  = 4'hF;
      exp_led = 7'h7F;
    end else begin
      d  = 2'((m_t / SD) % 4);
      on = m_ctrl[d];
`ifdef IO_DISP_BLANK_EN
      if ((m_t % SD) < BC) on = 1'b0;
`endif
      exp_an  = on ? ~(4'b0001 << d) : 4'hF;
      exp_led = on ? hex_tab[m_data[4*d +: 4]] : 7'h7F;
    end
    @(posedge CLK);
    #1;
    if (rst) begin
      m_t = 0; m_data = 16'h0; m_ctrl = 4'hF; m_sw_prev = 8'h0; m_sw_sync = 8'h0;
    end else begin
      m_t = m_t + 1;
      if (wen && addr == 4'h0) m_data = wdata[15:0];
      if (wen && addr == 4'h1) m_ctrl = wdata[3:0];
      m_sw_sync = m_sw_prev;
      m_sw_prev = sw;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] v);
    bus.IOAddr = a; bus.IOWriteData = v; bus.IOWriteEn = 1'b1;
    tick();
    bus.IOWriteEn = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    RESET = 1'b1;
    tick();
    tick();
    n_checks++;
    if (AN !== 4'hF) begin n_errors++; $display("FAIL reset_an: got %h expected %h", AN, 4'hF); end
    n_checks++;
    if (LED !== 7'h7F) begin n_errors++; $display("FAIL reset_led: got %h expected %h", LED, 7'h7F); end
    for (int a = 0; a < 4; a++) begin
      bus.IOAddr = 4'(a); #1;
      r = bus.IOReadData;
      n_checks++;
      if (r !== ((a == 1) ? 32'hF : 32'h0)) begin
        n_errors++; $display("FAIL reset_read%0d: got %h expected %h", a, r, (a == 1) ? 32'hF : 32'h0);
      end
    end
    RESET = 1'b0;
  endtask

  task automatic test_scan_default();
    logic [3:0] want_an;
    logic [31:0] r;
    for (int k = 1; k <= 16; k++) begin
      tick();
`ifdef IO_DISP_BLANK_EN
      want_an = (((k - 1) % SD) < BC) ? 4'hF : ~(4'b0001 << ((k - 1) / SD));
`else
      want_an = ~(4'b0001 << ((k - 1) / SD));
`endif
      n_checks++;
      if (AN !== want_an) begin n_errors++; $display("FAIL scan_an_k%0d: got %b expected %b", k, AN, want_an); end
      n_checks++;
      if (LED !== exp_led) begin n_errors++; $display("FAIL scan_led_k%0d: got %h expected %h", k, LED, exp_led); end
    end
    bus.IOAddr = 4'h3; #1;
    r = bus.IOReadData;
    n_checks++;
    if (r !== 32'd1) begin n_errors++; $display("FAIL frame_after_16: got %0d expected 1", r); end
  endtask

  task automatic test_data_write();
    logic [31:0] r;
    do_write(4'h0, 32'h0000_12AF);
    for (int k = 0; k < 4 * SD; k++) begin
      tick();
      n_checks++;
      if (AN !== exp_an || LED !== exp_led) begin
        n_errors++; $display("FAIL data_scan_%0d: got AN=%b LED=%b expected AN=%b LED=%b", k, AN, LED, exp_an, exp_led);
      end
    end
    bus.IOAddr = 4'h0; #1;
    r = bus.IOReadData;
    n_checks++;
    if (r !== 32'h0000_12AF) begin n_errors++; $display("FAIL data_read: got %h expected %h", r, 32'h0000_12AF); end
  endtask

  task automatic test_ctrl_mask();
    logic [31:0] r;
    do_write(4'h1, 32'hFFFF_FFF5);
    for (int k = 0; k < 4 * SD; k++) begin
      tick();
      n_checks++;
      if (AN !== exp_an || LED !== exp_led) begin
        n_errors++; $display("FAIL mask_scan_%0d: got AN=%b LED=%b expected AN=%b LED=%b", k, AN, LED, exp_an, exp_led);
      end
      n_checks++;
      if (AN[1] !== 1'b1 || AN[3] !== 1'b1) begin
        n_errors++; $display("FAIL mask_disabled_%0d: got AN=%b expected AN[1]=AN[3]=1", k, AN);
      end
    end
    bus.IOAddr = 4'h1; #1;
    r = bus.IOReadData;
    n_checks++;
    if (r !== 32'h5) begin n_errors++; $display("FAIL ctrl_read: got %h expected %h", r, 32'h5); end
    do_write(4'h1, 32'hF);
  endtask

  task automatic test_write_at_wrap();
    int guard;
    logic [3:0] nib;
    logic [1:0] nd;
    guard = 0;
    while ((m_t % SD) != SD - 1 && guard < 64) begin tick(); guard++; end
    nd  = 2'(((m_t / SD) + 1) % 4);
    nib = 4'($urandom_range(0, 15));
    do_write(4'h0, {16'h0, 16'(nib) << (4 * nd)});
    tick();
    n_checks++;
    if (LED !== hex_tab[nib] || AN !== exp_an) begin
      n_errors++; $display("FAIL wrap_write: got AN=%b LED=%b expected AN=%b LED=%b", AN, LED, exp_an, hex_tab[nib]);
    end
  endtask

  task automatic test_switches();
    logic [31:0] r;
    logic [31:0] d0;
    logic [31:0] c0;
    Sw = 8'h00;
    for (int k = 0; k < 3; k++) tick();
    Sw = 8'hA5;
    bus.IOAddr = 4'h2;
    tick(); #1;
    r = bus.IOReadData;
    n_checks++;
    if (r !== 32'h0) begin n_errors++; $display("FAIL sw_early: got %h expected %h", r, 32'h0); end
    tick(); #1;
    r = bus.IOReadData;
    n_checks++;
    if (r !== 32'hA5) begin n_errors++; $display("FAIL sw_synced: got %h expected %h", r, 32'hA5); end
    bus.IOAddr = 4'h0; #1; d0 = bus.IOReadData;
    bus.IOAddr = 4'h1; #1; c0 = bus.IOReadData;
    do_write(4'h2, 32'hFFFF_FFFF);
    do_write(4'h3, 32'h1234_5678);
    do_write(4'h9, 32'hDEAD_BEEF);
    bus.IOAddr = 4'h0; #1; r = bus.IOReadData;
    n_checks++;
    if (r !== d0) begin n_errors++; $display("FAIL ro_write_data: got %h expected %h", r, d0); end
    bus.IOAddr = 4'h1; #1; r = bus.IOReadData;
    n_checks++;
    if (r !== c0) begin n_errors++; $display("FAIL ro_write_ctrl: got %h expected %h", r, c0); end
    bus.IOAddr = 4'h2; #1; r = bus.IOReadData;
    n_checks++;
    if (r !== 32'hA5) begin n_errors++; $display("FAIL ro_write_sw: got %h expected %h", r, 32'hA5); end
    bus.IOAddr = 4'h9; #1; r = bus.IOReadData;
    n_checks++;
    if (r !== 32'h0) begin n_errors++; $display("FAIL unmapped_read: got %h expected %h", r, 32'h0); end
  endtask

  task automatic test_reset_midslot();
    int guard;
    logic [31:0] r;
    do_write(4'h0, 32'h0000_BEEF);
    guard = 0;
    while (!(((m_t / SD) % 4) == 2 && (m_t % SD) == 1) && guard < 64) begin tick(); guard++; end
    n_checks++;
    if (guard >= 64) begin n_errors++; $display("FAIL midslot_reach: got %0d cycles expected < 64", guard); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_checks++;
    if (AN !== 4'hF || LED !== 7'h7F) begin
      n_errors++; $display("FAIL midslot_reset: got AN=%h LED=%h expected AN=f LED=7f", AN, LED);
    end
    tick();
    n_checks++;
    if (AN !== ((SD > BC) ? exp_an : 4'hF) || LED !== exp_led) begin
      n_errors++; $display("FAIL midslot_resume: got AN=%b LED=%h expected AN=%b LED=%h", AN, LED, exp_an, exp_led);
    end
    for (int k = 1; k < SD; k++) tick();
    n_checks++;
    if (AN !== 4'b1110 || LED !== 7'h40) begin
      n_errors++; $display("FAIL midslot_digit0: got AN=%b LED=%h expected AN=1110 LED=40", AN, LED);
    end
    bus.IOAddr = 4'h0; #1; r = bus.IOReadData;
    n_checks++;
    if (r !== 32'h0) begin n_errors++; $display("FAIL midslot_data: got %h expected %h", r, 32'h0); end
  endtask

  task automatic test_random();
    logic [3:0]  ra;
    logic [31:0] r;
    for (int k = 0; k < 400; k++) begin
      RESET = ($urandom_range(0, 99) < 2);
      Sw = 8'($urandom);
      if ($urandom_range(0, 9) < 4) begin
        bus.IOAddr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
        bus.IOWriteData = $urandom;
        bus.IOWriteEn = 1'b1;
      end
      tick();
      bus.IOWriteEn = 1'b0;
      RESET = 1'b0;
      n_checks++;
      if (AN !== exp_an || LED !== exp_led) begin
        n_errors++; $display("FAIL rand_out_%0d: got AN=%b LED=%b expected AN=%b LED=%b", k, AN, LED, exp_an, exp_led);
      end
      ra = 4'($urandom_range(0, 5));
      bus.IOAddr = ra; #1;
      r = bus.IOReadData;
      n_checks++;
      if (r !== m_read(ra)) begin
        n_errors++; $display("FAIL rand_read_%0d addr %h: got %h expected %h", k, ra, r, m_read(ra));
      end
    end
  endtask

  initial begin
    RESET = 1'b1; Sw = 8'h00;
    bus.IOAddr = 4'h0; bus.IOWriteData = 32'h0; bus.IOWriteEn = 1'b0;
    m_t = 0; m_data = 16'h0; m_ctrl = 4'hF; m_sw_prev = 8'h0; m_sw_sync = 8'h0;
    exp_an = 4'hF; exp_led = 7'h7F;
    test_reset();
    test_scan_default();
    test_data_write();
    test_ctrl_mask();
    test_write_at_wrap();
    test_switches();
    test_reset_midslot();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
